// File: rtl/tx_stream_combiner.sv
// tx_stream_combiner: per-channel gain and enable on NUM_CH sample streams, saturating lane-wise sum toward the DAC.
// Latency: 2 clocks from input handshake to m_tvalid. Throughput is 1 beat/clock.
// Backpressure: holds up to 2 beats (stage 1 + output register). Inputs stall once both are full.
//
// Ports:
//   clock_i, reset_i        sole clock, synchronous active-high reset
//   s_tvalid_i/s_tready_o   per-channel input handshake; s_tdata_i packs channel-major, lane-minor samples
//   ch_enable_i, ch_gain_i  per-channel enable and signed gain (GAIN_W-2 fraction bits); sampled on fire
//   dbg_select_i            debug tap select: channel term, the sum (== NUM_CH), or zero
//   sat_clear_i             synchronous clear of sat_count_o
//   m_tvalid_o/m_tready_i   output handshake; m_tdata_o holds the combined lanes
//   dbg_tdata_o             debug tap, registered alongside m_tdata_o
//   sat_count_o             output beats with at least one clamped lane, sticky at all-ones
module tx_stream_combiner #(
  parameter int NUM_CH   = 4,
  parameter int LANES    = 8,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 16,
  parameter int SEL_W    = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic [NUM_CH-1:0]                  s_tvalid_i,
  input  logic [NUM_CH*LANES*SAMPLE_W-1:0]   s_tdata_i,
  output logic [NUM_CH-1:0]                  s_tready_o,
  input  logic [NUM_CH-1:0]                  ch_enable_i,
  input  logic [NUM_CH*GAIN_W-1:0]           ch_gain_i,
  input  logic [SEL_W-1:0]                   dbg_select_i,
  input  logic                               sat_clear_i,
  input  logic                               m_tready_i,
  output logic                               m_tvalid_o,
  output logic [LANES*SAMPLE_W-1:0]          m_tdata_o,
  output logic [LANES*SAMPLE_W-1:0]          dbg_tdata_o,
  output logic [31:0]                        sat_count_o
);

  localparam int PROD_W = SAMPLE_W + GAIN_W;
  localparam int SUM_W  = PROD_W + 3;   // headroom for up to 8 full-scale terms
  localparam int FRAC_W = GAIN_W - 2;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  function automatic logic [SAMPLE_W-1:0] clamp(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
    else                  return v[SAMPLE_W-1:0];
  endfunction

  function automatic logic is_clamped(input logic signed [SUM_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // Pipeline state
  logic                       s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0]   s1_term_q [NUM_CH][LANES];
  logic signed [PROD_W-1:0]   s1_term_d [NUM_CH][LANES];
  logic                       m_tvalid_q, m_tvalid_d;
  logic [LANES*SAMPLE_W-1:0]  m_tdata_q, m_tdata_d;
  logic [LANES*SAMPLE_W-1:0]  dbg_tdata_q, dbg_tdata_d;
  logic [31:0]                sat_count_q, sat_count_d;

  // Combinational datapath
  logic signed [PROD_W-1:0]   mul_term [NUM_CH][LANES];
  logic signed [SUM_W-1:0]    lane_sum [LANES];
  logic [LANES*SAMPLE_W-1:0]  sum_dat;
  logic [LANES*SAMPLE_W-1:0]  dbg_dat;
  logic                       sat_any;

  logic s2_ready, s1_ready, s2_load, fire;

  assign s2_ready = !m_tvalid_q || m_tready_i;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s2_load  = s1_valid_q && s2_ready;
  // Disabled channels never block: they count as valid and are drained.
  assign fire     = !reset_i && (|ch_enable_i) && (&(s_tvalid_i | ~ch_enable_i)) && s1_ready;
  assign s_tready_o = reset_i ? '0 : (~ch_enable_i | {NUM_CH{fire}});

  // Stage-1 terms: full product, arithmetic shift floors toward minus infinity.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < LANES; j++) begin
        mul_term[c][j] = '0;
        if (ch_enable_i[c]) begin
          mul_term[c][j] =
            (PROD_W'($signed(s_tdata_i[(c*LANES+j)*SAMPLE_W +: SAMPLE_W])) *
             PROD_W'($signed(ch_gain_i[c*GAIN_W +: GAIN_W]))) >>> FRAC_W;
        end
      end
    end
  end

  // Stage-2 sum, saturation and debug tap selection.
  always_comb begin
    sum_dat = '0;
    dbg_dat = '0;
    sat_any = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      lane_sum[j] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        lane_sum[j] = lane_sum[j] + SUM_W'(s1_term_q[c][j]);
      end
      sum_dat[j*SAMPLE_W +: SAMPLE_W] = clamp(lane_sum[j]);
      sat_any = sat_any | is_clamped(lane_sum[j]);
      for (int c = 0; c < NUM_CH; c++) begin
        if (32'(dbg_select_i) == c) begin
          dbg_dat[j*SAMPLE_W +: SAMPLE_W] = clamp(SUM_W'(s1_term_q[c][j]));
        end
      end
      if (32'(dbg_select_i) == NUM_CH) begin
        dbg_dat[j*SAMPLE_W +: SAMPLE_W] = clamp(lane_sum[j]);
      end
    end
  end

  // Next-state
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (fire)         s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < LANES; j++) begin
        s1_term_d[c][j] = fire ? mul_term[c][j] : s1_term_q[c][j];
      end
    end

    m_tvalid_d = m_tvalid_q;
    if (s2_load)         m_tvalid_d = 1'b1;
    else if (m_tready_i) m_tvalid_d = 1'b0;

    m_tdata_d   = s2_load ? sum_dat : m_tdata_q;
    dbg_tdata_d = s2_load ? dbg_dat : dbg_tdata_q;

    // Clear takes priority over a same-cycle increment.
    sat_count_d = sat_count_q;
    if (sat_clear_i) begin
      sat_count_d = '0;
    end else if (s2_load && sat_any && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      dbg_tdata_q <= '0;
      sat_count_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j < LANES; j++) begin
          s1_term_q[c][j] <= '0;
        end
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      dbg_tdata_q <= dbg_tdata_d;
      sat_count_q <= sat_count_d;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j < LANES; j++) begin
          s1_term_q[c][j] <= s1_term_d[c][j];
        end
      end
    end
  end

  assign m_tvalid_o  = m_tvalid_q;
  assign m_tdata_o   = m_tdata_q;
  assign dbg_tdata_o = dbg_tdata_q;
  assign sat_count_o = sat_count_q;

endmodule

// File: tb/tb_tx_stream_combiner.sv
// Bench for tx_stream_combiner: table of single-beat vectors with hand-derived
// results, plus streaming, backpressure, gating and mid-stream reset sequences.
// Outputs are scored against a queue filled as input beats are accepted.
module tb_tx_stream_combiner;
  localparam int NUM_CH = 4;
  localparam int LANES  = 8;
  localparam int SW     = 16;
  localparam int GW     = 16;
  localparam int SEL_W  = 4;
  localparam int DW     = LANES*SW;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_CH-1:0]         s_tvalid = '0;
  logic [NUM_CH*DW-1:0]      s_tdata = '0;
  logic [NUM_CH-1:0]         s_tready;
  logic [NUM_CH-1:0]         ch_enable = '0;
  logic [NUM_CH*GW-1:0]      ch_gain = '0;
  logic [SEL_W-1:0]          dbg_select = '0;
  logic                      sat_clear = 1'b0;
  logic                      m_tready = 1'b0;
  logic                      m_tvalid;
  logic [DW-1:0]             m_tdata;
  logic [DW-1:0]             dbg_tdata;
  logic [31:0]               sat_count;

  always #5 clk = ~clk;

  tx_stream_combiner #(.NUM_CH(NUM_CH), .LANES(LANES), .SAMPLE_W(SW), .GAIN_W(GW), .SEL_W(SEL_W)) dut (
    .clock_i(clk), .reset_i(rst),
    .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata), .s_tready_o(s_tready),
    .ch_enable_i(ch_enable), .ch_gain_i(ch_gain), .dbg_select_i(dbg_select),
    .sat_clear_i(sat_clear), .m_tready_i(m_tready), .m_tvalid_o(m_tvalid),
    .m_tdata_o(m_tdata), .dbg_tdata_o(dbg_tdata), .sat_count_o(sat_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  bit auto_push = 1'b0;
  bit fire_seen = 1'b0;
  bit fire_obs;

  typedef struct { logic [DW-1:0] m; logic [DW-1:0] d; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] en;
    int g0, g1, g2, g3;
    int s0, s1, s2, s3;
    logic [3:0] dsel;
    logic [15:0] em;
    logic [15:0] ed;
    bit sat;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Reference arithmetic from the current inputs: floor(sample*gain / 2^14), summed, clamped.
  function automatic exp_t model();
    exp_t e;
    longint t [NUM_CH];
    longint sum;
    logic signed [15:0] sv, gv;
    e.m = '0;
    e.d = '0;
    for (int j = 0; j < LANES; j++) begin
      sum = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        t[c] = 0;
        if (ch_enable[c]) begin
          sv = s_tdata[(c*LANES+j)*SW +: SW];
          gv = ch_gain[c*GW +: GW];
          t[c] = (longint'(sv) * longint'(gv)) >>> 14;
        end
        sum += t[c];
      end
      e.m[j*SW +: SW] = sat16(sum);
      for (int c = 0; c < NUM_CH; c++)
        if (int'(dbg_select) == c) e.d[j*SW +: SW] = sat16(t[c]);
      if (int'(dbg_select) == NUM_CH) e.d[j*SW +: SW] = sat16(sum);
    end
    return e;
  endfunction

  // Monitor: scores output handshakes, records input acceptance.
  always @(negedge clk) begin
    exp_t e;
    fire_obs = !rst && (ch_enable != 0) && (((s_tvalid & s_tready) | ~ch_enable) == 4'hF);
    fire_seen = fire_obs;
    if (!rst && m_tvalid && m_tready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %h expected no beat", m_tdata);
      end else begin
        e = sb.pop_front();
        chk("m_tdata", m_tdata, e.m);
        chk("dbg_tdata", dbg_tdata, e.d);
      end
    end
    if (fire_obs && auto_push) sb.push_back(model());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int g, input int s);
    ch_gain[c*GW +: GW] = 16'(g);
    for (int j = 0; j < LANES; j++) s_tdata[(c*LANES+j)*SW +: SW] = 16'(s);
  endtask

  task automatic drive_ramp(input int r);
    for (int j = 0; j < LANES; j++) s_tdata[j*SW +: SW] = 16'(r*8 + j);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((sb.size() != 0 || m_tvalid) && k < 200) begin
      step();
      k++;
    end
    chk(name, DW'(sb.size()), DW'(0));
  endtask

  task automatic add(input logic [3:0] en, input int g0, input int g1, input int g2, input int g3,
                     input int s0, input int s1, input int s2, input int s3,
                     input logic [3:0] dsel, input logic [15:0] em, input logic [15:0] ed, input bit sat);
    vec_t v;
    v.en = en; v.g0 = g0; v.g1 = g1; v.g2 = g2; v.g3 = g3;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
    v.dsel = dsel; v.em = em; v.ed = ed; v.sat = sat;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    int sat_exp;
    int r, out0, stall;
    logic [DW-1:0] held;

    // Disabled channels carry garbage (0x7000 at unity) that must not reach the sum.
    add(4'b0001, 16384, 16384, 16384, 16384, 16'h1234, 16'h7000, 16'h7000, 16'h7000, 4'd0,  16'h1234, 16'h1234, 0);
    add(4'b0011, 16384, 16384, 16384, 16384, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 4'd4,  16'h7fff, 16'h7fff, 1);
    add(4'b0011, 16384, 16384, 16384, 16384, -28672,   -28672,   16'h7000, 16'h7000, 4'd1,  16'h8000, 16'h9000, 1);
    add(4'b0001, 8192,  16384, 16384, 16384, -3,       16'h7000, 16'h7000, 16'h7000, 4'd0,  16'hfffe, 16'hfffe, 0);
    add(4'b0001, 8192,  16384, 16384, 16384, 3,        16'h7000, 16'h7000, 16'h7000, 4'd5,  16'h0001, 16'h0000, 0);
    add(4'b0101, 16384, 16384, -16384, 16384, 100,     16'h7000, 30,       16'h7000, 4'd2,  16'h0046, 16'hffe2, 0);
    add(4'b1111, 16384, 16384, 16384, 16384, 1000,     2000,     3000,     4000,     4'd3,  16'h2710, 16'h0fa0, 0);
    add(4'b0001, 32767, 16384, 16384, 16384, 32767,    16'h7000, 16'h7000, 16'h7000, 4'd0,  16'h7fff, 16'h7fff, 1);
    add(4'b0001, -32768, 16384, 16384, 16384, -32768,  16'h7000, 16'h7000, 16'h7000, 4'd0,  16'h7fff, 16'h7fff, 1);
    add(4'b0001, -32768, 16384, 16384, 16384, 32767,   16'h7000, 16'h7000, 16'h7000, 4'd4,  16'h8000, 16'h8000, 1);
    add(4'b1111, 32767, 32767, 32767, 32767, 32767,    32767,    32767,    32767,    4'd15, 16'h7fff, 16'h0000, 1);
    add(4'b0001, 1,     16384, 16384, 16384, -1,       16'h7000, 16'h7000, 16'h7000, 4'd0,  16'hffff, 16'hffff, 0);

    // Reset state
    step(); step();
    chk("rst_s_tready", DW'(s_tready), DW'(0));
    rst = 1'b0;
    #1;
    chk("rst_m_tvalid", DW'(m_tvalid), DW'(0));
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_dbg_tdata", dbg_tdata, '0);
    chk("rst_sat_count", DW'(sat_count), DW'(0));

    // No channel enabled: everything drained, nothing produced
    s_tvalid = 4'hF;
    m_tready = 1'b1;
    #1 chk("noen_s_tready", DW'(s_tready), DW'(4'hF));
    step(); step(); step();
    chk("noen_no_output", DW'(m_tvalid), DW'(0));
    s_tvalid = '0;

    // Table-driven single beats
    sat_exp = 0;
    foreach (tbl[i]) begin
      v = tbl[i];
      step();
      ch_enable = v.en;
      dbg_select = v.dsel;
      set_ch(0, v.g0, v.s0);
      set_ch(1, v.g1, v.s1);
      set_ch(2, v.g2, v.s2);
      set_ch(3, v.g3, v.s3);
      s_tvalid = v.en;
      e.m = {LANES{v.em}};
      e.d = {LANES{v.ed}};
      sb.push_back(e);
      #1 chk($sformatf("v%0d_fire", i), DW'(s_tready & v.en), DW'(v.en));
      step();
      s_tvalid = '0;
      chk($sformatf("v%0d_lat_k", i), DW'(m_tvalid), DW'(0));
      step();
      chk($sformatf("v%0d_lat_k1", i), DW'(m_tvalid), DW'(1));
      step();
      if (v.sat) sat_exp++;
      chk($sformatf("v%0d_sat_count", i), DW'(sat_count), DW'(sat_exp));
    end
    wait_drain("table_drain");

    // sat_clear on the same edge as a saturating stage-2 load
    step();
    ch_enable = 4'b0011;
    dbg_select = 4'd4;
    set_ch(0, 16384, 16'h7000);
    set_ch(1, 16384, 16'h7000);
    s_tvalid = 4'b0011;
    e.m = {LANES{16'h7fff}};
    e.d = {LANES{16'h7fff}};
    sb.push_back(e);
    step();
    s_tvalid = '0;
    sat_clear = 1'b1;
    chk("clr_lat_k", DW'(m_tvalid), DW'(0));
    step();
    sat_clear = 1'b0;
    chk("clr_m_tvalid", DW'(m_tvalid), DW'(1));
    chk("clr_sat_count", DW'(sat_count), DW'(0));
    wait_drain("clr_drain");

    // Continuous ramp with a 5-cycle downstream stall
    auto_push = 1'b1;
    ch_enable = 4'b0001;
    set_ch(0, 16384, 0);
    dbg_select = 4'd4;
    m_tready = 1'b1;
    out0 = n_out;
    r = 0;
    stall = 0;
    held = '0;
    drive_ramp(0);
    s_tvalid = 4'b0001;
    for (int cyc = 0; cyc < 80; cyc++) begin
      step();
      if (fire_seen) r++;
      if (r >= 20) s_tvalid = '0;
      else drive_ramp(r);
      if (stall > 0) begin
        chk("bp_frozen", m_tdata, held);
        chk("bp_m_tvalid", DW'(m_tvalid), DW'(1));
        chk("bp_s_tready", DW'(s_tready[0]), DW'(0));
        stall--;
        if (stall == 0) m_tready = 1'b1;
      end else if (cyc == 6) begin
        chk("bp_full_vld", DW'(m_tvalid), DW'(1));
        m_tready = 1'b0;
        held = m_tdata;
        stall = 5;
      end
    end
    wait_drain("ramp_drain");
    chk("ramp_count", DW'(n_out - out0), DW'(20));

    // Channel gating: enabled ch2 not valid blocks the beat; disabled ch3 still ready
    step();
    ch_enable = 4'b0111;
    set_ch(0, 16384, 10);
    set_ch(1, 16384, 20);
    set_ch(2, 16384, 30);
    set_ch(3, 16384, 16'h7000);
    s_tvalid = 4'b0011;
    #1;
    chk("gate_rdy_en", DW'(s_tready[2:0]), DW'(0));
    chk("gate_rdy_dis", DW'(s_tready[3]), DW'(1));
    step(); step(); step();
    chk("gate_no_output", DW'(m_tvalid), DW'(0));
    chk("gate_no_pending", DW'(sb.size()), DW'(0));
    s_tvalid = 4'b0111;
    #1 chk("gate_fire", DW'(s_tready), DW'(4'hF));
    step();
    s_tvalid = '0;
    step();
    chk("gate_m_tvalid", DW'(m_tvalid), DW'(1));
    chk("gate_sum", m_tdata, {LANES{16'd60}});
    wait_drain("gate_drain");

    // Reset with two beats in flight
    step();
    ch_enable = 4'b0001;
    set_ch(0, 16384, 16'h0100);
    m_tready = 1'b0;
    s_tvalid = 4'b0001;
    step(); step(); step();
    chk("mrst_pre_vld", DW'(m_tvalid), DW'(1));
    rst = 1'b1;
    s_tvalid = '0;
    sb.delete();
    #1 chk("mrst_s_tready", DW'(s_tready), DW'(0));
    step();
    rst = 1'b0;
    chk("mrst_m_tvalid", DW'(m_tvalid), DW'(0));
    chk("mrst_m_tdata", m_tdata, '0);
    chk("mrst_dbg_tdata", dbg_tdata, '0);
    m_tready = 1'b1;
    set_ch(0, 16384, 16'h0200);
    s_tvalid = 4'b0001;
    #1 chk("mrst_fire", DW'(s_tready[0]), DW'(1));
    step();
    s_tvalid = '0;
    chk("mrst_lat_k", DW'(m_tvalid), DW'(0));
    step();
    chk("mrst_lat_k1", DW'(m_tvalid), DW'(1));
    chk("mrst_data", m_tdata, {LANES{16'h0200}});
    wait_drain("mrst_drain");
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
